// File: rtl/bist_session_manager_if.sv
// Host-side handshake bundle for bist_session_manager: start/abort in, status and verdict out.
// Latency: none (wires only).
// Backpressure: none; start is sampled only while the manager is idle, so the host just holds or pulses it.
// Ports: start, abort (host -> manager); busy, done, pass, fail, timeout, captured_sig, session_count
//        (manager -> host). With BIST_STICKY_FAIL_EN defined, sticky_fail and fail_count are also present.
interface bist_session_manager_if #(
  parameter int SIG_WIDTH = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic                 timeout;
  logic [SIG_WIDTH-1:0] captured_sig;
  logic [CNT_WIDTH-1:0] session_count;
`ifdef BIST_STICKY_FAIL_EN
  logic                 sticky_fail;
  logic [CNT_WIDTH-1:0] fail_count;

  modport master (output start, abort,
                  input  busy, done, pass, fail, timeout, captured_sig, session_count,
                         sticky_fail, fail_count);
  modport slave  (input  start, abort,
                  output busy, done, pass, fail, timeout, captured_sig, session_count,
                         sticky_fail, fail_count);
`else
  modport master (output start, abort,
                  input  busy, done, pass, fail, timeout, captured_sig, session_count);
  modport slave  (input  start, abort,
                  output busy, done, pass, fail, timeout, captured_sig, session_count);
`endif
endinterface

// File: rtl/bist_session_manager.sv
// Sequences one BIST session (clear, run, settle, evaluate, report) and returns a pass/fail/timeout verdict.
// Latency: start accepted to done = 1 + CLEAR_CYCLES + N_run + 3 cycles; a timeout reports after TIMEOUT_CYCLES RUN cycles.
// Backpressure: none; start while busy is dropped (no queuing), abort returns to IDLE at the next edge.
// Ports: clock, reset (sync, active-high); host (bist_session_manager_if.slave: start/abort/busy/done/verdict/counters);
//        finish, signature, fault_detected from the BIST engine; bist_reset, testmode to the BIST engine.
// Option: define BIST_STICKY_FAIL_EN to add sticky_fail and a saturating fail_count on the host interface.
module bist_session_manager #(
  parameter int                   SIG_WIDTH      = 4,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG     = 4'b0011,
  parameter int                   CLEAR_CYCLES   = 2,
  parameter int                   TIMEOUT_CYCLES = 16,
  parameter int                   CNT_WIDTH      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  bist_session_manager_if.slave  host,
  input  logic                   finish,
  input  logic [SIG_WIDTH-1:0]   signature,
  input  logic                   fault_detected,
  output logic                   bist_reset,
  output logic                   testmode
);

  // One shared phase counter serves both CLEAR and RUN; it restarts on every state change.
  localparam int MAX_PHASE = (TIMEOUT_CYCLES > CLEAR_CYCLES) ? TIMEOUT_CYCLES : CLEAR_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_EVAL, S_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 done_c;
  logic                 timeout_hit;
  logic                 abort_act;
  logic                 start_acc;
  logic                 eval_now;
  logic                 bad;
  logic                 pass_q, fail_q, timeout_q;
  logic [SIG_WIDTH-1:0] captured_q;
  logic [CNT_WIDTH-1:0] session_q;

  assign abort_act = host.abort && (state_q != S_IDLE);
  assign start_acc = (state_q == S_IDLE) && host.start && !host.abort;
  assign eval_now  = (state_q == S_EVAL) && !abort_act;
  assign bad       = (signature != GOLDEN_SIG) || fault_detected;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == S_CLEAR || state_q == S_RUN)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bist_reset  = 1'b1;
    testmode    = 1'b0;
    done_c      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_acc) state_d = S_CLEAR;
      S_CLEAR:  if (cnt_q == CW'(CLEAR_CYCLES - 1)) state_d = S_RUN;
      S_RUN: begin
        bist_reset = 1'b0;
        testmode   = 1'b1;
        // finish on the final counted cycle still wins over the timeout
        if (finish) begin
          state_d = S_SETTLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_REPORT;
        end
      end
      // engine registers fault_detected one cycle after finish; keep it running
      S_SETTLE: begin
        bist_reset = 1'b0;
        testmode   = 1'b1;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        bist_reset = 1'b0;
        testmode   = 1'b1;
        state_d    = S_REPORT;
      end
      S_REPORT: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    // abort overrides everything in the same cycle: engine parked, no report
    if (abort_act) begin
      state_d     = S_IDLE;
      bist_reset  = 1'b1;
      testmode    = 1'b0;
      done_c      = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      captured_q <= '0;
      session_q  <= '0;
    end else if (start_acc || abort_act) begin
      // an aborted session leaves the verdict in its cleared state
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (eval_now) begin
      captured_q <= signature;
      pass_q     <= ~bad;
      fail_q     <= bad;
    end else if (timeout_hit) begin
      fail_q    <= 1'b1;
      timeout_q <= 1'b1;
    end else if (state_q == S_REPORT) begin
      session_q <= session_q + 1'b1;
    end
  end

`ifdef BIST_STICKY_FAIL_EN
  logic                 sticky_q;
  logic [CNT_WIDTH-1:0] fail_cnt_q;
  logic                 fail_set;

  assign fail_set = (eval_now && bad) || timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q   <= 1'b0;
      fail_cnt_q <= '0;
    end else if (fail_set) begin
      sticky_q <= 1'b1;
      if (fail_cnt_q != {CNT_WIDTH{1'b1}})
        fail_cnt_q <= fail_cnt_q + 1'b1;
    end
  end

  assign host.sticky_fail = sticky_q;
  assign host.fail_count  = fail_cnt_q;
`else
  // without the sticky option, fail reflects only the latest session
`endif

  assign host.busy          = (state_q != S_IDLE);
  assign host.done          = done_c;
  assign host.pass          = pass_q;
  assign host.fail          = fail_q;
  assign host.timeout       = timeout_q;
  assign host.captured_sig  = captured_q;
  assign host.session_count = session_q;

endmodule

// File: tb/tb_bist_session_manager.sv
module tb_bist_session_manager;
  localparam int         C    = 2;
  localparam int         T    = 16;
  localparam logic [3:0] GOLD = 4'b0011;

  logic       clock = 1'b0;
  logic       reset;
  logic       finish;
  logic [3:0] signature;
  logic       fault_detected;
  logic       bist_reset;
  logic       testmode;

  bist_session_manager_if #(.SIG_WIDTH(4), .CNT_WIDTH(8)) hif ();

  bist_session_manager #(
    .SIG_WIDTH(4), .GOLDEN_SIG(GOLD), .CLEAR_CYCLES(C), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .host           (hif),
    .finish         (finish),
    .signature      (signature),
    .fault_detected (fault_detected),
    .bist_reset     (bist_reset),
    .testmode       (testmode)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Session model: tracks k = cycles since acceptance and derives every output from
  // the window arithmetic clear(C) / run(N) / settle / eval / report.
  bit         m_active, m_to, m_pass, m_fail, m_tout, m_sticky;
  int         m_k, m_nrun;
  logic [3:0] m_sig;
  logic [7:0] m_count, m_fcnt;

  function automatic int done_k();
    return m_to ? C + T + 1 : C + m_nrun + 3;
  endfunction

  task automatic note_fail();
    m_sticky = 1'b1;
    if (m_fcnt != 8'hFF) m_fcnt++;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_active = 0; m_k = 0; m_nrun = 0; m_to = 0;
      m_pass = 0; m_fail = 0; m_tout = 0; m_sig = '0;
      m_count = '0; m_sticky = 0; m_fcnt = '0;
    end else if (m_active && hif.abort) begin
      m_active = 0; m_pass = 0; m_fail = 0; m_tout = 0;
    end else if (!m_active) begin
      if (hif.start && !hif.abort) begin
        m_active = 1; m_k = 1; m_nrun = 0; m_to = 0;
        m_pass = 0; m_fail = 0; m_tout = 0;
      end
    end else if (m_nrun == 0 && !m_to) begin
      if (m_k > C) begin
        if (finish) m_nrun = m_k - C;
        else if (m_k - C == T) begin
          m_to = 1; m_fail = 1; m_tout = 1; note_fail();
        end
      end
      m_k++;
    end else if (m_k == done_k()) begin
      m_count++;
      m_active = 0;
    end else begin
      if (m_nrun != 0 && m_k == C + m_nrun + 2) begin
        m_sig  = signature;
        m_pass = (signature == GOLD) && !fault_detected;
        m_fail = !m_pass;
        if (m_fail) note_fail();
      end
      m_k++;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit ended, win, e_tm, e_done;
      ended  = (m_nrun != 0) || m_to;
      win    = m_active && (m_k > C) &&
               (!ended || m_k <= (m_to ? C + T : C + m_nrun + 2));
      e_tm   = win && !hif.abort;
      e_done = m_active && ended && (m_k == done_k()) && !hif.abort;
      check("busy",          hif.busy,          m_active);
      check("testmode",      testmode,          e_tm);
      check("bist_reset",    bist_reset,        !e_tm);
      check("done",          hif.done,          e_done);
      check("pass",          hif.pass,          m_pass);
      check("fail",          hif.fail,          m_fail);
      check("timeout",       hif.timeout,       m_tout);
      check("captured_sig",  hif.captured_sig,  m_sig);
      check("session_count", hif.session_count, m_count);
`ifdef BIST_STICKY_FAIL_EN
      check("sticky_fail",   hif.sticky_fail,   m_sticky);
      check("fail_count",    hif.fail_count,    m_fcnt);
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one session starting now (cycle 1 = start cycle); finish on RUN cycle fin_at (0 = never).
  task automatic do_session(input logic [3:0] sig, input logic flt, input int fin_at, input bit early,
                            output int tm_cycles, output int done_at, output logic tm_at_done);
    signature = sig;
    fault_detected = flt;
    tm_cycles = 0;
    done_at = 0;
    tm_at_done = 1'bx;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      hif.start = (c == 1);
      finish = (fin_at != 0 && c == 1 + C + fin_at) || (early && c <= 1 + C);
      @(negedge clock);
      if (testmode) tm_cycles++;
      if (hif.done) begin
        done_at = c;
        tm_at_done = testmode;
      end
      step();
    end
    hif.start = 1'b0;
    finish = 1'b0;
  endtask

  int   tmc, dat, nd;
  logic tmd;

  initial begin
    reset = 1'b1; hif.start = 1'b0; hif.abort = 1'b0;
    finish = 1'b0; signature = GOLD; fault_detected = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_bist_reset", bist_reset, 1);
    check("rst_testmode",   testmode, 0);
    check("rst_busy",       hif.busy, 0);
    check("rst_done",       hif.done, 0);
    check("rst_count",      hif.session_count, 0);
    step();

    // good run, finish on RUN cycle 7
    do_session(4'b0011, 1'b0, 7, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("good_done_at", dat, 13);
    check("good_tm_cycles", tmc, 9);
    check("good_pass", hif.pass, 1);
    check("good_fail", hif.fail, 0);
    check("good_sig", hif.captured_sig, 4'b0011);
    check("good_count", hif.session_count, 1);
    step();

    // bad signature
    do_session(4'b1010, 1'b0, 7, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("badsig_done_at", dat, 13);
    check("badsig_fail", hif.fail, 1);
    check("badsig_pass", hif.pass, 0);
    check("badsig_sig", hif.captured_sig, 4'b1010);
    step();

    // good signature but fault flag
    do_session(4'b0011, 1'b1, 7, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("fault_fail", hif.fail, 1);
    check("fault_pass", hif.pass, 0);
    check("fault_count", hif.session_count, 3);
    step();

    // timeout: finish never arrives
    do_session(4'b0011, 1'b0, 0, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("to_done_at", dat, 20);
    check("to_tm_cycles", tmc, 16);
    check("to_tm_in_report", tmd, 0);
    check("to_fail", hif.fail, 1);
    check("to_timeout", hif.timeout, 1);
    check("to_pass", hif.pass, 0);
    check("to_count", hif.session_count, 4);
    step();

    // finish on the very cycle the timeout would expire: finish wins
    do_session(4'b0011, 1'b0, 16, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("edge_done_at", dat, 22);
    check("edge_pass", hif.pass, 1);
    check("edge_timeout", hif.timeout, 0);
    step();

    // finish also high in IDLE/CLEAR is ignored; real finish on RUN cycle 5
    do_session(4'b0011, 1'b0, 5, 1'b1, tmc, dat, tmd);
    @(negedge clock);
    check("early_done_at", dat, 11);
    check("early_pass", hif.pass, 1);
    check("early_count", hif.session_count, 6);
    step();

    // abort on RUN cycle 3, with a stray start during CLEAR
    nd = 0;
    for (int c = 1; c <= 30; c++) begin
      hif.start = (c == 1 || c == 2);
      hif.abort = (c == 6);
      @(negedge clock);
      if (hif.done) nd++;
      if (c == 5) check("abort_busy_before", hif.busy, 1);
      if (c == 7) begin
        check("abort_busy_after", hif.busy, 0);
        check("abort_bist_reset", bist_reset, 1);
      end
      step();
    end
    hif.start = 1'b0;
    hif.abort = 1'b0;
    @(negedge clock);
    check("abort_no_done", nd, 0);
    check("abort_count", hif.session_count, 6);
    check("abort_pass", hif.pass, 0);
    check("abort_fail", hif.fail, 0);
    step();

    // start held high: next session accepted only from IDLE after done
    dat = 0;
    for (int c = 1; c <= 16; c++) begin
      hif.start = 1'b1;
      finish = (c == 1 + C + 7);
      @(negedge clock);
      if (hif.done && dat == 0) dat = c;
      if (c == 14) check("held_busy_idle", hif.busy, 0);
      if (c == 15) check("held_busy_restart", hif.busy, 1);
      step();
    end
    hif.start = 1'b0;
    finish = 1'b0;
    check("held_done_at", dat, 13);
    hif.abort = 1'b1;
    step();
    hif.abort = 1'b0;
    @(negedge clock);
    check("held_count", hif.session_count, 7);
    step();

    // reset in the middle of a session
    hif.start = 1'b1;
    step();
    hif.start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", hif.busy, 0);
    check("mid_rst_bist_reset", bist_reset, 1);
    check("mid_rst_count", hif.session_count, 0);
    check("mid_rst_fail", hif.fail, 0);
    step();

`ifdef BIST_STICKY_FAIL_EN
    do_session(4'b1010, 1'b0, 7, 1'b0, tmc, dat, tmd);
    do_session(4'b0011, 1'b0, 7, 1'b0, tmc, dat, tmd);
    @(negedge clock);
    check("sticky_set", hif.sticky_fail, 1);
    check("sticky_fail_count", hif.fail_count, 1);
    check("sticky_pass", hif.pass, 1);
    step();
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
